// File: rtl/lcd_nibble_receiver_pkg.sv
// Shared types and helpers for the HD44780-style nibble receiver.
// Maps LCD DDRAM addresses onto the 32-byte mirror buffer.
package lcd_nibble_receiver_pkg;

    typedef enum logic [1:0] {
        StBoot8,
        StHi,
        StLo
    } rx_state_e;

    localparam int unsigned BufDepth  = 32;
    localparam logic [7:0]  CharSpace = 8'h20;

    localparam int unsigned ErrRs    = 0;
    localparam int unsigned ErrPulse = 1;
    localparam int unsigned ErrBusy  = 2;
    localparam int unsigned ErrRead  = 3;

    // Only 0x00-0x0F and 0x40-0x4F are mirrored.
    function automatic logic addr_visible(logic [6:0] addr);
        return addr[5:4] == 2'b00;
    endfunction

    function automatic logic [4:0] buf_index(logic [6:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

endpackage

// File: rtl/lcd_nibble_receiver_if.sv
// 4-bit LCD bus: E strobe, RS, RW and data nibble.
interface lcd_nibble_receiver_if;
    logic       e;
    logic       rs;
    logic       rw;
    logic [3:0] dat;

    modport master (output e, rs, rw, dat);
    modport slave  (input  e, rs, rw, dat);
endinterface

// File: rtl/lcd_sync_edge.sv
// Bus synchronizer with E falling-edge detect and saturating E-high width check.
module lcd_sync_edge #(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned MinEHigh   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [3:0] dat_i,
    output logic       fall_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [3:0] dat_o,
    output logic       short_o
);

    localparam int unsigned CntW = $clog2(MinEHigh + 1);

    logic [SyncStages-1:0][6:0] sync_q;
    logic                       e_s;
    logic                       e_prev_q;
    logic [CntW-1:0]            cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q[0] <= {e_i, rs_i, rw_i, dat_i};
            for (int i = 1; i < int'(SyncStages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_prev_q <= e_s;
            if (!e_s) begin
                cnt_q <= '0;
            end else if (cnt_q != CntW'(MinEHigh)) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign e_s   = sync_q[SyncStages-1][6];
    assign rs_o  = sync_q[SyncStages-1][5];
    assign rw_o  = sync_q[SyncStages-1][4];
    assign dat_o = sync_q[SyncStages-1][3:0];

    // cnt_q still holds the full high width in the cycle the fall is seen.
    assign fall_o  = e_prev_q & ~e_s;
    assign short_o = fall_o & (cnt_q < CntW'(MinEHigh));

endmodule

// File: rtl/lcd_nibble_receiver.sv
// HD44780-style 4-bit bus receiver: assembles bytes, executes the writer's command
// subset and mirrors both 16-char rows into a readable character buffer.
module lcd_nibble_receiver
    import lcd_nibble_receiver_pkg::*;
#(
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned MinEHigh    = 4,
    parameter int unsigned BusyCycles  = 40,
    parameter int unsigned ClearCycles = 1600
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    lcd_nibble_receiver_if.slave   lcd_io,
    input  logic [4:0]             rd_idx_i,
    output logic [7:0]             rd_char_o,
    output logic                   byte_valid_o,
    output logic                   byte_rs_o,
    output logic [7:0]             byte_data_o,
    output logic                   busy_o,
    output logic                   mode4_o,
    output logic                   disp_on_o,
    output logic [3:0]             err_o
);

    localparam int unsigned BusyW = $clog2(ClearCycles + 1);

    logic       fall, rs_s, rw_s, short_pulse;
    logic [3:0] dat_s;

    lcd_sync_edge #(
        .SyncStages (SyncStages),
        .MinEHigh   (MinEHigh)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .e_i     (lcd_io.e),
        .rs_i    (lcd_io.rs),
        .rw_i    (lcd_io.rw),
        .dat_i   (lcd_io.dat),
        .fall_o  (fall),
        .rs_o    (rs_s),
        .rw_o    (rw_s),
        .dat_o   (dat_s),
        .short_o (short_pulse)
    );

    rx_state_e        state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic             hi_rs_q, hi_rs_d;
    logic             mode4_q, mode4_d;
    logic             disp_on_q, disp_on_d;
    logic             id_q, id_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       err_q, err_d;
    logic [BusyW-1:0] busy_q, busy_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_rs_q, byte_rs_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic [7:0]       rd_char_q;
    logic [7:0]       mem_q [BufDepth];

    logic             exec, exec_rs, wr_en, clear_all;
    logic [7:0]       exec_byte;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        hi_rs_d      = hi_rs_q;
        mode4_d      = mode4_q;
        disp_on_d    = disp_on_q;
        id_d         = id_q;
        addr_d       = addr_q;
        err_d        = err_q;
        busy_d       = (busy_q != '0) ? busy_q - BusyW'(1) : busy_q;
        byte_valid_d = 1'b0;
        byte_rs_d    = byte_rs_q;
        byte_data_d  = byte_data_q;
        exec         = 1'b0;
        exec_rs      = 1'b0;
        exec_byte    = '0;
        wr_en        = 1'b0;
        clear_all    = 1'b0;

        if (fall) begin
            if (short_pulse) err_d[ErrPulse] = 1'b1;
            if (rw_s) begin
                err_d[ErrRead] = 1'b1;
            end else begin
                if (busy_o) err_d[ErrBusy] = 1'b1;
                unique case (state_q)
                    StBoot8: begin
                        exec      = 1'b1;
                        exec_rs   = rs_s;
                        exec_byte = {dat_s, 4'h0};
                    end
                    StHi: begin
                        hi_d    = dat_s;
                        hi_rs_d = rs_s;
                        state_d = StLo;
                    end
                    StLo: begin
                        state_d = StHi;
                        if (rs_s != hi_rs_q) begin
                            err_d[ErrRs] = 1'b1;
                        end else begin
                            exec      = 1'b1;
                            exec_rs   = rs_s;
                            exec_byte = {hi_q, dat_s};
                        end
                    end
                    default: state_d = StBoot8;
                endcase
            end
        end

        if (exec) begin
            byte_valid_d = 1'b1;
            byte_rs_d    = exec_rs;
            byte_data_d  = exec_byte;
            busy_d       = BusyW'(BusyCycles);
            if (exec_rs) begin
                wr_en  = addr_visible(addr_q);
                addr_d = id_q ? addr_q + 7'd1 : addr_q - 7'd1;
            end else if (exec_byte[7]) begin
                addr_d = exec_byte[6:0];
            end else if (exec_byte[6]) begin
                // CGRAM address: not mirrored
            end else if (exec_byte[5]) begin
                mode4_d = ~exec_byte[4];
                state_d = exec_byte[4] ? StBoot8 : StHi;
            end else if (exec_byte[4]) begin
            end else if (exec_byte[3]) begin
                disp_on_d = exec_byte[2];
            end else if (exec_byte[2]) begin
                id_d = exec_byte[1];
            end else if (exec_byte[1]) begin
                addr_d = '0;
                busy_d = BusyW'(ClearCycles);
            end else if (exec_byte[0]) begin
                clear_all = 1'b1;
                addr_d    = '0;
                id_d      = 1'b1;
                busy_d    = BusyW'(ClearCycles);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StBoot8;
            hi_q         <= '0;
            hi_rs_q      <= 1'b0;
            mode4_q      <= 1'b0;
            disp_on_q    <= 1'b0;
            id_q         <= 1'b1;
            addr_q       <= '0;
            err_q        <= '0;
            busy_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            hi_rs_q      <= hi_rs_d;
            mode4_q      <= mode4_d;
            disp_on_q    <= disp_on_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            byte_valid_q <= byte_valid_d;
            byte_rs_q    <= byte_rs_d;
            byte_data_q  <= byte_data_d;
        end
    end

    // Read is registered from the pre-write contents, so a same-cycle write shows next read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_char_q <= '0;
            for (int i = 0; i < int'(BufDepth); i++) mem_q[i] <= CharSpace;
        end else begin
            rd_char_q <= mem_q[rd_idx_i];
            if (clear_all) begin
                for (int i = 0; i < int'(BufDepth); i++) mem_q[i] <= CharSpace;
            end else if (wr_en) begin
                mem_q[buf_index(addr_q)] <= exec_byte;
            end
        end
    end

    assign rd_char_o    = rd_char_q;
    assign byte_valid_o = byte_valid_q;
    assign byte_rs_o    = byte_rs_q;
    assign byte_data_o  = byte_data_q;
    assign busy_o       = busy_q != '0;
    assign mode4_o      = mode4_q;
    assign disp_on_o    = disp_on_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver with a byte-level behavioural model.
module tb_lcd_nibble_receiver;

    localparam int MinEHigh    = 4;
    localparam int BusyCycles  = 40;
    localparam int ClearCycles = 1600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rd_idx = '0;
    logic [7:0] rd_char, byte_data;
    logic       byte_valid, byte_rs, busy, mode4, disp_on;
    logic [3:0] err;

    lcd_nibble_receiver_if lcd_if ();

    lcd_nibble_receiver #(
        .SyncStages  (2),
        .MinEHigh    (MinEHigh),
        .BusyCycles  (BusyCycles),
        .ClearCycles (ClearCycles)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lcd_io       (lcd_if),
        .rd_idx_i     (rd_idx),
        .rd_char_o    (rd_char),
        .byte_valid_o (byte_valid),
        .byte_rs_o    (byte_rs),
        .byte_data_o  (byte_data),
        .busy_o       (busy),
        .mode4_o      (mode4),
        .disp_on_o    (disp_on),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       rs;
        bit [7:0] data;
    } byte_t;

    byte_t    exp_q[$];
    byte_t    popped;
    bit [7:0] m_buf[32];
    bit [6:0] m_addr;
    bit       m_id, m_disp, m_mode4, m_have_hi, m_hi_rs;
    bit [3:0] m_hi, m_err;
    int       m_busy_left = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        foreach (m_buf[i]) m_buf[i] = 8'h20;
        m_addr = '0; m_id = 1'b1; m_disp = 1'b0; m_mode4 = 1'b0;
        m_have_hi = 1'b0; m_hi_rs = 1'b0; m_hi = '0; m_err = '0;
        exp_q.delete();
    endtask

    task automatic model_exec(bit rs, bit [7:0] b);
        exp_q.push_back('{rs: rs, data: b});
        if (rs) begin
            if (m_addr < 16) m_buf[m_addr] = b;
            else if (m_addr >= 64 && m_addr < 80) m_buf[m_addr - 48] = b;
            m_addr = m_id ? m_addr + 7'd1 : m_addr - 7'd1;
        end else if (b >= 8'h80) m_addr = b[6:0];
        else if (b >= 8'h40) begin end
        else if (b >= 8'h20) begin m_mode4 = !b[4]; m_have_hi = 1'b0; end
        else if (b >= 8'h10) begin end
        else if (b >= 8'h08) m_disp = b[2];
        else if (b >= 8'h04) m_id = b[1];
        else if (b >= 8'h02) m_addr = '0;
        else if (b == 8'h01) begin
            foreach (m_buf[i]) m_buf[i] = 8'h20;
            m_addr = '0; m_id = 1'b1;
        end
    endtask

    task automatic model_strobe(bit rs, bit rw, bit [3:0] d, int high);
        if (high < MinEHigh) m_err[1] = 1'b1;
        if (rw) m_err[3] = 1'b1;
        else if (!m_mode4) model_exec(rs, {d, 4'h0});
        else if (!m_have_hi) begin m_have_hi = 1'b1; m_hi = d; m_hi_rs = rs; end
        else begin
            m_have_hi = 1'b0;
            if (rs != m_hi_rs) m_err[0] = 1'b1;
            else model_exec(rs, {m_hi, d});
        end
    endtask

    task automatic nib(bit rs, bit rw, bit [3:0] d, int high);
        lcd_if.rs = rs; lcd_if.rw = rw; lcd_if.dat = d; lcd_if.e = 1'b1;
        tick(high);
        lcd_if.e = 1'b0;
        model_strobe(rs, rw, d, high);
        tick(3);
    endtask

    task automatic wr_byte(bit rs, bit [7:0] b, int gap = -1);
        if (m_mode4) begin
            nib(rs, 1'b0, b[7:4], 6);
            nib(rs, 1'b0, b[3:0], 6);
        end else begin
            nib(rs, 1'b0, b[7:4], 6);
        end
        if (gap < 0) gap = (!rs && b >= 1 && b <= 3) ? ClearCycles + 10 : BusyCycles + 10;
        tick(gap);
    endtask

    task automatic rd(int idx, output logic [7:0] v);
        rd_idx = 5'(idx);
        @(posedge clk);
        @(negedge clk);
        v = rd_char;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_buf(int idx);
        logic [7:0] v;
        rd(idx, v);
        chk($sformatf("buf[%0d]", idx), int'(v), int'(m_buf[idx]));
    endtask

    task automatic chk_lit(int idx, int exp);
        logic [7:0] v;
        rd(idx, v);
        chk($sformatf("lit_buf[%0d]", idx), int'(v), exp);
    endtask

    task automatic chk_state();
        chk("mode4", int'(mode4), int'(m_mode4));
        chk("disp_on", int'(disp_on), int'(m_disp));
        chk("err", int'(err), int'(m_err));
        chk("pending_bytes", exp_q.size(), 0);
    endtask

    // Every-cycle compare of byte stream and busy against the model.
    always @(negedge clk) begin
        if (rst) begin
            m_busy_left = 0;
        end else begin
            if (byte_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 1, 0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("byte_rs", int'(byte_rs), int'(popped.rs));
                    chk("byte_data", int'(byte_data), int'(popped.data));
                    m_busy_left = (!popped.rs && popped.data >= 1 && popped.data <= 3) ?
                                  ClearCycles : BusyCycles;
                end
            end
            chk("busy", int'(busy), int'(m_busy_left > 0));
            if (m_busy_left > 0) m_busy_left--;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    string s1, s2;

    initial begin
        lcd_if.e = 1'b0; lcd_if.rs = 1'b0; lcd_if.rw = 1'b0; lcd_if.dat = '0;
        model_reset();
        s1 = "12345678";
        s2 = "87654321";
        tick(5);
        @(negedge clk);
        chk("rst_outputs", int'({rd_char, byte_valid, byte_rs, byte_data, busy, mode4,
                                 disp_on, err}), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk_lit(0, 8'h20);
        chk_lit(31, 8'h20);

        // Init; first strobe at exactly the minimum E width
        nib(1'b0, 1'b0, 4'h3, MinEHigh); tick(BusyCycles + 10);
        wr_byte(1'b0, 8'h30);
        wr_byte(1'b0, 8'h30);
        chk("lit_mode4_after3", int'(mode4), 0);
        wr_byte(1'b0, 8'h20);
        chk("lit_mode4_after4", int'(mode4), 1);
        chk("lit_err_init", int'(err), 0);
        chk_state();

        wr_byte(1'b0, 8'h0C);
        chk("lit_disp_on", int'(disp_on), 1);
        wr_byte(1'b0, 8'h06);
        wr_byte(1'b0, 8'h80);
        for (int i = 0; i < 8; i++) wr_byte(1'b1, s1[i]);
        wr_byte(1'b0, 8'hC0);
        for (int i = 0; i < 8; i++) wr_byte(1'b1, s2[i]);
        chk_state();
        chk_lit(0, 8'h31);
        chk_lit(16, 8'h38);
        chk_lit(7, 8'h38);
        chk_lit(23, 8'h31);
        chk_lit(8, 8'h20);
        for (int i = 0; i < 32; i++) chk_buf(i);

        // Clear: buffer blanked, busy held for the long time
        wr_byte(1'b0, 8'h01, 800);
        chk("lit_busy_mid_clear", int'(busy), 1);
        tick(820);
        chk("lit_busy_after_clear", int'(busy), 0);
        chk_lit(0, 8'h20);
        for (int i = 0; i < 32; i++) chk_buf(i);

        // RS mismatch between nibbles drops the byte
        nib(1'b0, 1'b0, 4'h8, 6);
        nib(1'b1, 1'b0, 4'h0, 6);
        tick(20);
        chk("lit_err_rs", int'(err), 4'b0001);
        chk_state();
        wr_byte(1'b0, 8'h80);
        wr_byte(1'b1, 8'h5A);
        chk_lit(0, 8'h5A);

        // Decrementing entry on row 1
        wr_byte(1'b0, 8'h04);
        wr_byte(1'b0, 8'hC5);
        wr_byte(1'b1, 8'h41);
        wr_byte(1'b1, 8'h42);
        chk_lit(21, 8'h41);
        chk_lit(20, 8'h42);
        chk_buf(22);
        chk_state();

        // Strobe while busy
        wr_byte(1'b0, 8'h06, 5);
        m_err[2] = 1'b1;
        wr_byte(1'b0, 8'h0C);
        chk("lit_err_busy", int'(err[2]), 1);
        chk_state();

        // Read strobe is flagged and otherwise ignored
        nib(1'b0, 1'b1, 4'h5, 6);
        tick(10);
        chk("lit_err_read", int'(err[3]), 1);
        chk_state();

        // Short E pulse still processed
        lcd_if.rs = 1'b0; lcd_if.rw = 1'b0; lcd_if.dat = 4'h8; lcd_if.e = 1'b1;
        tick(2);
        lcd_if.e = 1'b0;
        model_strobe(1'b0, 1'b0, 4'h8, 2);
        tick(3);
        nib(1'b0, 1'b0, 4'h1, 6);
        tick(BusyCycles + 10);
        wr_byte(1'b1, 8'h51);
        chk("lit_err_pulse", int'(err[1]), 1);
        chk_lit(1, 8'h51);
        chk_state();

        // Reset after a lone high nibble, then a clean re-init
        nib(1'b0, 1'b0, 4'h8, 6);
        tick(5);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(2);
        chk("lit_err_after_rst", int'(err), 0);
        chk("lit_mode4_after_rst", int'(mode4), 0);
        wr_byte(1'b0, 8'h30);
        wr_byte(1'b0, 8'h20);
        chk("lit_mode4_reinit", int'(mode4), 1);
        wr_byte(1'b0, 8'h80);
        wr_byte(1'b1, 8'h48);
        chk_lit(0, 8'h48);
        chk_buf(1);
        chk_buf(21);
        chk_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
